booth_seq_bus_master: RTL and testbench

//  Sequential radix-2 Booth signed multiplier with a shared-bus output stage.
//  - Computes a 2*WIDTH-bit two's-complement product, one Booth step per clock.
//  - Requests the shared result bus, then drives the product for exactly one cycle.
//  - Sits directly upstream of the tristate bus buffer: bus_data feeds its data input, bus_oe its enable.

---
 rtl/booth_seq_bus_master.sv | 135 +++++++++++++
 tb/tb_booth_seq_bus_master.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_bus_master.sv
// Sequential radix-2 Booth signed multiplier, one step per clock. The finished
// product is placed on a shared result bus for one granted cycle.
module booth_seq_bus_master #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 bus_grant,
    output logic                 busy,
    output logic                 bus_req,
    output logic                 bus_oe,
    output logic [2*WIDTH-1:0]   bus_data,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WAIT_GRANT,
        DRIVE
    } state_t;

    localparam int             CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;

    // acc carries one guard bit so that M = -2^(WIDTH-1) stays exact.
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   mcand;
    logic [WIDTH:0]   acc_sum;
    logic [WIDTH:0]   acc_nxt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_nxt;
    logic             q_1;
    logic [CW-1:0]    cnt;
    logic             last_step;

    // One Booth step: add/subtract M, then arithmetic shift of {A, Q, q_1}.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        acc_sum = acc;
        case ({q[0], q_1})
            2'b01:   acc_sum = acc + mcand;
            2'b10:   acc_sum = acc - mcand;
            default: acc_sum = acc;
        endcase
        acc_nxt = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
        q_nxt   = {acc_sum[0], q[WIDTH-1:1]};
    end

    assign last_step = (cnt == LAST_STEP);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start)     state_nxt = CALC;
            CALC:       if (last_step) state_nxt = WAIT_GRANT;
            WAIT_GRANT: if (bus_grant) state_nxt = DRIVE;
            DRIVE:                     state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Outputs decode straight from the state, so reset to IDLE clears them.
    always_comb begin
        busy    = 1'b0;
        bus_req = 1'b0;
        bus_oe  = 1'b0;
        done    = 1'b0;
        case (state)
            CALC:       busy = 1'b1;
            WAIT_GRANT: begin
                busy    = 1'b1;
                bus_req = 1'b1;
            end
            DRIVE:      begin
                busy   = 1'b1;
                bus_oe = 1'b1;
                done   = 1'b1;
            end
            default:    ;
        endcase
    end

    // Datapath registers and the product register behind the bus buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            mcand    <= '0;
            q        <= '0;
            q_1      <= 1'b0;
            cnt      <= '0;
            bus_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        mcand <= {multiplicand[WIDTH-1], multiplicand};
                        q     <= multiplier;
                        q_1   <= 1'b0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    q   <= q_nxt;
                    q_1 <= q[0];
                    cnt <= cnt + CW'(1);
                    if (last_step) begin
                        bus_data <= {acc_nxt[WIDTH-1:0], q_nxt};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_bus_master.sv
// Directed bench for booth_seq_bus_master (WIDTH=8): cycle-exact handshake
// timing and hand-computed products.
module tb_booth_seq_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        bus_grant;
    logic        busy;
    logic        bus_req;
    logic        bus_oe;
    logic [15:0] bus_data;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;

    booth_seq_bus_master #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .bus_grant    (bus_grant),
        .busy         (busy),
        .bus_req      (bus_req),
        .bus_oe       (bus_oe),
        .bus_data     (bus_data),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_idle(input string tag, input logic [15:0] data_exp);
        check({tag, "_busy"},  32'(busy),    32'd0);
        check({tag, "_req"},   32'(bus_req), 32'd0);
        check({tag, "_oe"},    32'(bus_oe),  32'd0);
        check({tag, "_done"},  32'(done),    32'd0);
        check({tag, "_data"},  32'(bus_data), 32'(data_exp));
    endtask

    // Full transaction with bus_grant held 1. Entered and left in an IDLE cycle.
    // With junk_in_drive set, start is raised in the DRIVE cycle with other operands.
    task automatic mul_check(input string tag, input logic [7:0] m, input logic [7:0] q,
                             input logic [15:0] expected, input bit junk_in_drive);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        step();
        start        = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check({tag, "_calc_busy"}, 32'(busy),    32'd1);
            check({tag, "_calc_req"},  32'(bus_req), 32'd0);
            check({tag, "_calc_oe"},   32'(bus_oe),  32'd0);
            step();
        end
        check({tag, "_wait_req"},  32'(bus_req),  32'd1);
        check({tag, "_wait_oe"},   32'(bus_oe),   32'd0);
        check({tag, "_wait_data"}, 32'(bus_data), 32'(expected));
        step();
        check({tag, "_drive_oe"},   32'(bus_oe),   32'd1);
        check({tag, "_drive_done"}, 32'(done),     32'd1);
        check({tag, "_drive_req"},  32'(bus_req),  32'd0);
        check({tag, "_drive_data"}, 32'(bus_data), 32'(expected));
        if (junk_in_drive) begin
            multiplicand = 8'h55;
            multiplier   = 8'h33;
            start        = 1'b1;
        end
        step();
        start = 1'b0;
        check_idle({tag, "_after"}, expected);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        bus_grant    = 1'b1;
        step();
        step();
        check_idle("reset", 16'h0000);
        rst_n = 1'b1;
        step();
        check_idle("idle", 16'h0000);

        // Grant tied high throughout: bus_req in cycle 9, bus_oe in cycle 10.
        mul_check("p3x5", 8'd3, 8'd5, 16'h000F, 1'b0);

        // Back-to-back, with a start in the DRIVE cycle that must be ignored;
        // the second bus_oe then lands 11 cycles after the first.
        mul_check("m3x5", 8'hFD, 8'd5, 16'hFFF1, 1'b1);
        mul_check("p5xm3", 8'd5, 8'hFD, 16'hFFF1, 1'b0);

        mul_check("m128sq", 8'h80, 8'h80, 16'h4000, 1'b0);
        mul_check("p127xm128", 8'h7F, 8'h80, 16'hC080, 1'b0);
        mul_check("zero", 8'h00, 8'hFF, 16'h0000, 1'b0);

        // Grant withheld for 6 cycles of WAIT_GRANT; start pulses are ignored.
        bus_grant    = 1'b0;
        multiplicand = 8'd3;
        multiplier   = 8'd5;
        start        = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        multiplicand = 8'd100;
        multiplier   = 8'd100;
        start        = 1'b1;
        step();
        start = 1'b0;
        for (int c = 4; c <= 8; c++) step();
        for (int c = 9; c <= 14; c++) begin
            check("hold_req",  32'(bus_req), 32'd1);
            check("hold_oe",   32'(bus_oe),  32'd0);
            check("hold_busy", 32'(busy),    32'd1);
            if (c == 11) begin
                multiplicand = 8'hF0;
                multiplier   = 8'h0F;
                start        = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        check("hold_data", 32'(bus_data), 32'h0000_000F);
        check("hold_req15", 32'(bus_req), 32'd1);
        bus_grant = 1'b1;
        step();
        check("grant_oe",   32'(bus_oe),   32'd1);
        check("grant_done", 32'(done),     32'd1);
        check("grant_data", 32'(bus_data), 32'h0000_000F);
        step();
        check_idle("grant_after", 16'h000F);

        // Reset during CALC step 4 aborts without any bus_oe.
        multiplicand = 8'hFD;
        multiplier   = 8'd5;
        start        = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle("mid_rst", 16'h0000);
        for (int c = 0; c < 12; c++) begin
            check("mid_rst_no_oe", 32'(bus_oe | bus_req | busy), 32'd0);
            step();
        end
        mul_check("p7xm9", 8'd7, 8'hF7, 16'hFFC1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
